// File: rtl/timer_core.sv
// Timer engine: 1us prescaler, 1ms divider and three 16-bit reloadable down-counters
// that raise a one-cycle interrupt on expiry.
module timer_core #(
  parameter int unsigned NUM_US_PER_MS = 1000
) (
  input  logic        mclk,
  input  logic        h_reset,
  input  logic [9:0]  cfg_pulse_1us,
  input  logic [2:0]  cfg_timer_update,
  input  logic [18:0] cfg_timer0,
  input  logic [18:0] cfg_timer1,
  input  logic [18:0] cfg_timer2,
  output logic        pulse_1us,
  output logic        pulse_1ms,
  output logic [2:0]  timer_intr,
  output logic [2:0]  timer_busy
);

  localparam logic [9:0] MS_LAST = 10'(NUM_US_PER_MS - 1);

  logic [9:0]        us_cnt_q, us_cnt_d;
  logic              pulse_1us_q, pulse_1us_d;
  logic [9:0]        ms_cnt_q, ms_cnt_d;
  logic              pulse_1ms_q, pulse_1ms_d;
  logic [2:0][15:0]  cnt_q, cnt_d;
  logic [2:0]        run_q, run_d;
  logic [2:0]        intr_q, intr_d;
  logic [2:0][18:0]  cfg_all;
  logic [2:0]        tick;

  assign cfg_all = {cfg_timer2, cfg_timer1, cfg_timer0};

  // A count above the (possibly just lowered) limit is treated as terminal.
  always_comb begin
    us_cnt_d    = us_cnt_q + 10'd1;
    pulse_1us_d = 1'b0;
    if (us_cnt_q >= cfg_pulse_1us) begin
      us_cnt_d    = '0;
      pulse_1us_d = 1'b1;
    end
  end

  always_comb begin
    ms_cnt_d    = ms_cnt_q;
    pulse_1ms_d = 1'b0;
    if (pulse_1us_q) begin
      if (ms_cnt_q >= MS_LAST) begin
        ms_cnt_d    = '0;
        pulse_1ms_d = 1'b1;
      end else begin
        ms_cnt_d = ms_cnt_q + 10'd1;
      end
    end
  end

  always_comb begin
    tick = '0;
    for (int i = 0; i < 3; i++) begin
      tick[i] = cfg_all[i][16] ? pulse_1ms_q : pulse_1us_q;
    end
  end

  // A load strobe wins over a coincident tick, which is dropped.
  always_comb begin
    cnt_d  = cnt_q;
    run_d  = run_q;
    intr_d = '0;
    for (int i = 0; i < 3; i++) begin
      if (cfg_timer_update[i]) begin
        cnt_d[i] = cfg_all[i][15:0];
        run_d[i] = cfg_all[i][18];
      end else if (run_q[i] && tick[i]) begin
        if (cnt_q[i] != 16'd0) begin
          cnt_d[i] = cnt_q[i] - 16'd1;
        end else begin
          intr_d[i] = 1'b1;
          if (cfg_all[i][17]) begin
            cnt_d[i] = cfg_all[i][15:0];
          end else begin
            run_d[i] = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge mclk) begin
    if (h_reset) begin
      us_cnt_q    <= '0;
      pulse_1us_q <= 1'b0;
      ms_cnt_q    <= '0;
      pulse_1ms_q <= 1'b0;
      cnt_q       <= '0;
      run_q       <= '0;
      intr_q      <= '0;
    end else begin
      us_cnt_q    <= us_cnt_d;
      pulse_1us_q <= pulse_1us_d;
      ms_cnt_q    <= ms_cnt_d;
      pulse_1ms_q <= pulse_1ms_d;
      cnt_q       <= cnt_d;
      run_q       <= run_d;
      intr_q      <= intr_d;
    end
  end

  assign pulse_1us  = pulse_1us_q;
  assign pulse_1ms  = pulse_1ms_q;
  assign timer_intr = intr_q;
  assign timer_busy = run_q;

endmodule

// File: tb/tb_timer_core.sv
// Scoreboard bench for timer_core: expected per-cycle output bits are queued as
// stimulus is driven and compared on the following falling edge.
module tb_timer_core;

  logic        mclk;
  logic        h_reset;
  logic [9:0]  cfg_pulse_1us;
  logic [2:0]  cfg_timer_update;
  logic [18:0] cfg_timer0, cfg_timer1, cfg_timer2;
  logic        pulse_1us, pulse_1ms;
  logic [2:0]  timer_intr, timer_busy;

  timer_core #(.NUM_US_PER_MS(1000)) dut (
    .mclk             (mclk),
    .h_reset          (h_reset),
    .cfg_pulse_1us    (cfg_pulse_1us),
    .cfg_timer_update (cfg_timer_update),
    .cfg_timer0       (cfg_timer0),
    .cfg_timer1       (cfg_timer1),
    .cfg_timer2       (cfg_timer2),
    .pulse_1us        (pulse_1us),
    .pulse_1ms        (pulse_1ms),
    .timer_intr       (timer_intr),
    .timer_busy       (timer_busy)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  typedef struct {
    int   at;
    int   sig;
    logic val;
  } expect_t;

  expect_t expQ[$];
  int cyc = 0;
  int nCompared = 0;
  int nMismatched = 0;

  always @(posedge mclk) cyc <= cyc + 1;

  function automatic string sigName(int id);
    case (id)
      0: return "pulse_1us";
      1: return "pulse_1ms";
      2: return "intr0";
      3: return "intr1";
      4: return "intr2";
      5: return "busy0";
      6: return "busy1";
      default: return "busy2";
    endcase
  endfunction

  function automatic logic sampleSig(int id);
    case (id)
      0: return pulse_1us;
      1: return pulse_1ms;
      2: return timer_intr[0];
      3: return timer_intr[1];
      4: return timer_intr[2];
      5: return timer_busy[0];
      6: return timer_busy[1];
      default: return timer_busy[2];
    endcase
  endfunction

  task automatic checkOutput(string tag, logic obs, logic exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s at cycle %0d: got %b, expected %b", tag, cyc, obs, exp);
    end
  endtask

  task automatic expectNow(int sig, logic val);
    expQ.push_back('{cyc, sig, val});
  endtask

  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  function automatic logic [18:0] timerCfg(logic en, logic per, logic ms, logic [15:0] val);
    return {en, per, ms, val};
  endfunction

  // Pops every expectation due for the state after the latest rising edge.
  always @(negedge mclk) begin
    expect_t e;
    while (expQ.size() > 0 && expQ[0].at <= cyc) begin
      e = expQ.pop_front();
      if (e.at < cyc) begin
        nCompared++;
        nMismatched++;
        $display("[TB] FAIL stale_%s due cycle %0d: not compared, expected %b", sigName(e.sig), e.at, e.val);
      end else begin
        checkOutput(sigName(e.sig), sampleSig(e.sig), e.val);
      end
    end
  end

  // Phase A driver: prescale 9, all three timers loaded together at rel 4.
  task automatic applyStimulus(int rel);
    cfg_timer_update = 3'b000;
    case (rel)
      3: begin
        cfg_timer0 = timerCfg(1'b1, 1'b1, 1'b0, 16'd4);
        cfg_timer1 = timerCfg(1'b1, 1'b0, 1'b0, 16'd2);
        cfg_timer2 = timerCfg(1'b1, 1'b1, 1'b0, 16'd7);
        cfg_timer_update = 3'b111;
      end
      30: begin
        cfg_timer2 = timerCfg(1'b1, 1'b1, 1'b0, 16'd3);
        cfg_timer_update = 3'b100;
      end
      160: begin
        cfg_timer2 = timerCfg(1'b0, 1'b1, 1'b0, 16'd3);
        cfg_timer_update = 3'b100;
      end
      200: cfg_timer2 = timerCfg(1'b1, 1'b1, 1'b0, 16'd3);
      default: ;
    endcase
  endtask

  initial begin
    int k0;
    int b0;
    h_reset          = 1'b1;
    cfg_pulse_1us    = 10'd9;
    cfg_timer_update = 3'b000;
    cfg_timer0       = '0;
    cfg_timer1       = '0;
    cfg_timer2       = '0;

    repeat (3) step();
    k0 = cyc;
    for (int s = 0; s < 8; s++) expectNow(s, 1'b0);
    h_reset = 1'b0;
    $display("[TB] reset released at cycle %0d", k0);

    for (int rel = 1; rel <= 10005; rel++) begin
      step();
      applyStimulus(rel);
      expectNow(0, (rel % 10) == 0);
      expectNow(1, rel == 10001);
      if (rel >= 5 && rel <= 160) begin
        expectNow(2, rel >= 51 && ((rel - 51) % 50) == 0);
        expectNow(5, 1'b1);
      end
      if (rel >= 5 && rel <= 1031) begin
        expectNow(3, rel == 31);
        expectNow(6, rel <= 30);
      end
      if (rel >= 5 && rel <= 400) begin
        expectNow(4, rel == 71 || rel == 111 || rel == 151);
        expectNow(7, rel <= 160);
      end
    end

    b0 = cyc;
    $display("[TB] prescale 0 and live tick switch from cycle %0d", b0);
    cfg_pulse_1us    = 10'd0;
    cfg_timer2       = timerCfg(1'b1, 1'b1, 1'b0, 16'd0);
    cfg_timer_update = 3'b100;
    for (int rel = 1; rel <= 2005; rel++) begin
      step();
      cfg_timer_update = 3'b000;
      if (rel == 20) cfg_timer2 = timerCfg(1'b1, 1'b1, 1'b1, 16'd0);
      if (rel == 1500) begin
        cfg_timer0 = timerCfg(1'b1, 1'b1, 1'b0, 16'd100);
        cfg_timer1 = timerCfg(1'b1, 1'b1, 1'b0, 16'd500);
        cfg_timer_update = 3'b011;
      end
      if (rel == 2005) h_reset = 1'b1;
      expectNow(0, 1'b1);
      expectNow(1, rel == 1001 || rel == 2001);
      if (rel >= 2) begin
        expectNow(4, (rel <= 20) || rel == 1002 || rel == 2002);
        expectNow(7, 1'b1);
      end
      if (rel >= 1501) begin
        expectNow(5, 1'b1);
        expectNow(6, 1'b1);
      end
    end

    $display("[TB] mid-count reset at cycle %0d", cyc + 1);
    for (int rel = 2006; rel <= 2100; rel++) begin
      step();
      h_reset = 1'b0;
      expectNow(0, rel != 2006);
      for (int s = 1; s < 8; s++) expectNow(s, 1'b0);
    end

    step();
    step();
    checkOutput("queue_drained", expQ.size() == 0, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
